// File: rtl/led_hex_sequencer_if.sv
// Bus bundle for led_hex_sequencer.
//   cpu_*  : CPU write port, passed through to out_* with priority
//   req_*  : display request handshake (valid/ready) and its payload
//   out_*  : shared write port into the LED display registers
//   done   : one-cycle pulse after the last digit write of a request
// The master modport is the requester/CPU side; the slave modport is the
// sequencer.
interface led_hex_sequencer_if;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_value;
    logic        req_blank;
    logic [3:0]  req_dp;
    logic        out_we;
    logic [7:0]  out_addr;
    logic [7:0]  out_data;
    logic        done;

    modport master (
        output cpu_we, cpu_addr, cpu_data,
        output req_valid, req_value, req_blank, req_dp,
        input  req_ready, out_we, out_addr, out_data, done
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_data,
        input  req_valid, req_value, req_blank, req_dp,
        output req_ready, out_we, out_addr, out_data, done
    );
endinterface

// File: rtl/led_hex_sequencer.sv
// Write sequencer/arbiter for a 4-digit memory-mapped LED display.
// A 16-bit value accepted over valid/ready is turned into four 7-segment
// register writes (digit 0 first) at BASE_ADDR..BASE_ADDR+3. CPU writes
// share the same output port and always win; a pending digit write is then
// simply delayed by one cycle.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : led_hex_sequencer_if.slave (cpu_*, req_*, out_*, done)
// All outputs are registered.
module led_hex_sequencer #(
    parameter logic [7:0] BASE_ADDR      = 8'hF0,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_hex_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  index_q, index_d;
    logic [15:0] value_q, value_d;
    logic        blank_q, blank_d;
    logic [3:0]  dp_q, dp_d;
    logic        req_ready_q, req_ready_d;
    logic        out_we_q, out_we_d;
    logic [7:0]  out_addr_q, out_addr_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;

    logic        hs;
    logic        issue;
    logic [1:0]  issue_idx;
    logic [15:0] src_value;
    logic        src_blank;
    logic [3:0]  src_dp;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] seg_lut(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
            4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
            4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
            4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] digit_pat(input logic [15:0] v, input logic blank,
                                             input logic [3:0] dp, input logic [1:0] idx);
        logic [1:0] msd;
        logic [7:0] p;
        // Most significant nonzero nibble; stays 0 for value 0 so digit 0
        // is never blanked.
        msd = 2'd0;
        for (int i = 1; i < 4; i++)
            if (v[i*4 +: 4] != 4'h0) msd = 2'(i);
        if (blank && (idx > msd)) p = 8'hFF;
        else                      p = seg_lut(v[{idx, 2'b00} +: 4]);
        if (dp[idx]) p[7] = 1'b0;
        if (!SEG_ACTIVE_LOW) p = ~p;
        return p;
    endfunction

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        value_d     = value_q;
        blank_d     = blank_q;
        dp_d        = dp_q;
        req_ready_d = req_ready_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        issue_idx   = index_q;

        hs = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
        // Digit 0 goes out on the handshake edge itself, straight from the
        // request inputs, so the first write lands the cycle after capture.
        src_value = hs ? bus.req_value : value_q;
        src_blank = hs ? bus.req_blank : blank_q;
        src_dp    = hs ? bus.req_dp    : dp_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (hs) begin
                    value_d     = bus.req_value;
                    blank_d     = bus.req_blank;
                    dp_d        = bus.req_dp;
                    req_ready_d = 1'b0;
                    state_d     = S_WRITE;
                    issue_idx   = 2'd0;
                    index_d     = 2'd0;
                    if (!bus.cpu_we) begin
                        issue   = 1'b1;
                        index_d = 2'd1;
                    end
                end
            end
            S_WRITE: begin
                if (!bus.cpu_we) begin
                    issue = 1'b1;
                    if (index_q == 2'd3) begin
                        state_d = S_DONE;
                        index_d = 2'd0;
                    end else begin
                        index_d = index_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                // req_ready stays low here; IDLE raises it a cycle later.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                index_d     = 2'd0;
                req_ready_d = 1'b0;
            end
        endcase

        out_we_d   = 1'b0;
        out_addr_d = 8'h00;
        out_data_d = 8'h00;
        if (bus.cpu_we) begin
            out_we_d   = 1'b1;
            out_addr_d = bus.cpu_addr;
            out_data_d = bus.cpu_data;
        end else if (issue) begin
            out_we_d   = 1'b1;
            out_addr_d = BASE_ADDR + {6'b0, issue_idx};
            out_data_d = digit_pat(src_value, src_blank, src_dp, issue_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            index_q     <= 2'd0;
            value_q     <= 16'h0000;
            blank_q     <= 1'b0;
            dp_q        <= 4'h0;
            req_ready_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_addr_q  <= 8'h00;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            dp_q        <= dp_d;
            req_ready_q <= req_ready_d;
            out_we_q    <= out_we_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_we    = out_we_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_led_hex_sequencer.sv
// Directed bench for led_hex_sequencer. A second instance (BASE_ADDR=FE,
// active-high segments) shares the stimulus to cover address wrap and
// pattern inversion.
module tb_led_hex_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_hex_sequencer_if b1 ();
    led_hex_sequencer_if b2 ();

    assign b2.cpu_we    = b1.cpu_we;
    assign b2.cpu_addr  = b1.cpu_addr;
    assign b2.cpu_data  = b1.cpu_data;
    assign b2.req_valid = b1.req_valid;
    assign b2.req_value = b1.req_value;
    assign b2.req_blank = b1.req_blank;
    assign b2.req_dp    = b1.req_dp;

    led_hex_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    led_hex_sequencer #(.BASE_ADDR(8'hFE), .SEG_ACTIVE_LOW(1'b0))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {out_we, out_addr, out_data, done, req_ready}
    function automatic logic [31:0] obs();
        return {13'd0, b1.out_we, b1.out_addr, b1.out_data, b1.done, b1.req_ready};
    endfunction

    function automatic logic [31:0] ex(input logic we, input logic [7:0] a,
                                       input logic [7:0] d, input logic dn, input logic rdy);
        return {13'd0, we, a, d, dn, rdy};
    endfunction

    // One request from ready state. exp holds digit 0..3 data in bytes 0..3.
    // cpu_slot: write-slot index (0 = handshake edge) taken by a CPU write
    // to 10/55, or -1 for none. wrap: also check the second instance.
    task automatic seq(input string tag, input logic [15:0] v, input logic bl,
                       input logic [3:0] dp, input logic [31:0] exp,
                       input int cpu_slot, input bit wrap);
        int d = 0;
        int nw = (cpu_slot >= 0) ? 5 : 4;
        b1.req_valid = 1'b1;
        b1.req_value = v;
        b1.req_blank = bl;
        b1.req_dp    = dp;
        for (int e = 0; e < nw; e++) begin
            b1.cpu_we   = (e == cpu_slot);
            b1.cpu_addr = 8'h10;
            b1.cpu_data = 8'h55;
            tick();
            b1.req_valid = 1'b0;
            b1.req_value = ~v;           // must not affect the sequence in flight
            b1.req_blank = ~bl;
            b1.req_dp    = ~dp;
            b1.cpu_we    = 1'b0;
            if (e == cpu_slot) begin
                chk({tag, "_cpu"}, obs(), ex(1'b1, 8'h10, 8'h55, 1'b0, 1'b0));
            end else begin
                chk($sformatf("%s_d%0d", tag, d), obs(),
                    ex(1'b1, 8'hF0 + 8'(d), exp[d*8 +: 8], 1'b0, 1'b0));
                if (wrap)
                    chk($sformatf("%s_wrap%0d", tag, d),
                        {15'd0, b2.out_we, b2.out_addr, b2.out_data},
                        {15'd0, 1'b1, 8'hFE + 8'(d), ~exp[d*8 +: 8]});
                d++;
            end
        end
        tick();
        chk({tag, "_done"}, obs(), ex(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        tick();
        chk({tag, "_rdy"}, obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    endtask

    initial begin
        rst_n        = 1'b0;
        b1.cpu_we    = 1'b0;
        b1.cpu_addr  = 8'h00;
        b1.cpu_data  = 8'h00;
        b1.req_valid = 1'b1;
        b1.req_value = 16'h1234;
        b1.req_blank = 1'b0;
        b1.req_dp    = 4'h0;
        tick();
        tick();
        chk("reset", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        b1.req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));

        // CPU pass-through while idle
        b1.cpu_we = 1'b1; b1.cpu_addr = 8'h20; b1.cpu_data = 8'h33;
        tick();
        b1.cpu_we = 1'b0;
        chk("cpu_idle", obs(), ex(1'b1, 8'h20, 8'h33, 1'b0, 1'b1));
        tick();

        seq("t1234",  16'h1234, 1'b0, 4'b0000, 32'hF9A4B099, -1, 1'b1);
        seq("tA5blk", 16'h00A5, 1'b1, 4'b0000, 32'hFFFF8892, -1, 1'b0);
        seq("tzero",  16'h0000, 1'b1, 4'b0001, 32'hFFFFFF40, -1, 1'b0);
        seq("tblkdp", 16'h0100, 1'b1, 4'b1000, 32'h7FF9C0C0, -1, 1'b0);
        seq("tFEDC",  16'hFEDC, 1'b0, 4'b0110, 32'h8E0621C6, -1, 1'b0);
        seq("t9B80",  16'h9B80, 1'b1, 4'b0000, 32'h908380C0, -1, 1'b0);
        seq("tcpu1",  16'h1234, 1'b0, 4'b0000, 32'hF9A4B099,  1, 1'b0);
        seq("tcpu0",  16'h1234, 1'b0, 4'b0000, 32'hF9A4B099,  0, 1'b0);

        // Reset after two digit writes aborts the sequence
        b1.req_valid = 1'b1; b1.req_value = 16'h1234; b1.req_blank = 1'b0; b1.req_dp = 4'h0;
        tick();
        b1.req_valid = 1'b0;
        chk("abort_d0", obs(), ex(1'b1, 8'hF0, 8'h99, 1'b0, 1'b0));
        tick();
        chk("abort_d1", obs(), ex(1'b1, 8'hF1, 8'hB0, 1'b0, 1'b0));
        rst_n = 1'b0;
        tick();
        chk("abort_rst", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        chk("abort_rdy", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
        tick();
        chk("abort_nodone", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));

        // req_valid held high: one capture per IDLE visit
        b1.req_valid = 1'b1; b1.req_value = 16'h00A5; b1.req_blank = 1'b1; b1.req_dp = 4'h0;
        tick(); chk("b2b_a0", obs(), ex(1'b1, 8'hF0, 8'h92, 1'b0, 1'b0));
        tick(); chk("b2b_a1", obs(), ex(1'b1, 8'hF1, 8'h88, 1'b0, 1'b0));
        tick(); chk("b2b_a2", obs(), ex(1'b1, 8'hF2, 8'hFF, 1'b0, 1'b0));
        tick(); chk("b2b_a3", obs(), ex(1'b1, 8'hF3, 8'hFF, 1'b0, 1'b0));
        tick(); chk("b2b_adone", obs(), ex(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        tick(); chk("b2b_gap", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
        tick(); chk("b2b_b0", obs(), ex(1'b1, 8'hF0, 8'h92, 1'b0, 1'b0));
        b1.req_valid = 1'b0;
        tick(); chk("b2b_b1", obs(), ex(1'b1, 8'hF1, 8'h88, 1'b0, 1'b0));
        tick(); chk("b2b_b2", obs(), ex(1'b1, 8'hF2, 8'hFF, 1'b0, 1'b0));
        tick(); chk("b2b_b3", obs(), ex(1'b1, 8'hF3, 8'hFF, 1'b0, 1'b0));
        tick(); chk("b2b_bdone", obs(), ex(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        tick(); chk("b2b_brdy", obs(), ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
